// File: rtl/approx_accum.sv
// Multi-term accumulator with a lower-part-OR approximate adder and a start/count FSM.
// One term per cycle while in ACCUM. The result is valid 1 cycle after the last term and is held until out_ready_o... out_ready_i.
module approx_accum #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int APPROX_BITS = 4,
  parameter int MAX_TERMS   = 16,
  localparam int CW         = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CW-1:0]        num_terms_i,
  input  logic                 approx_en_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_sum_o,
  output logic                 out_sat_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        n_q, n_d;
  logic                 sat_q, sat_d;
  logic                 mode_q, mode_d;

  logic [ACC_WIDTH-1:0] op;
  logic [ACC_WIDTH-1:0] ex_sum, ap_sum, add_sum, add_res;
  logic                 ex_cout, ap_cout, add_cout;
  logic [CW-1:0]        n_clamp;
  logic [CW-1:0]        cnt_inc;

  assign op = ACC_WIDTH'(in_data_i);
  assign {ex_cout, ex_sum} = {1'b0, acc_q} + {1'b0, op};

  generate
    if (APPROX_BITS > 0) begin : g_approx
      localparam int K = APPROX_BITS;
      logic [K-1:0]           lo;
      logic                   cin;
      logic [ACC_WIDTH-K:0]   hi_sum;
      assign lo     = acc_q[K-1:0] | op[K-1:0];
      // Carry into the exact upper part is guessed from the top approximated bit pair.
      assign cin    = acc_q[K-1] & op[K-1];
      assign hi_sum = {1'b0, acc_q[ACC_WIDTH-1:K]} + {1'b0, op[ACC_WIDTH-1:K]}
                      + (ACC_WIDTH-K+1)'(cin);
      assign ap_sum  = {hi_sum[ACC_WIDTH-K-1:0], lo};
      assign ap_cout = hi_sum[ACC_WIDTH-K];
    end else begin : g_exact_only
      assign ap_sum  = ex_sum;
      assign ap_cout = ex_cout;
    end
  endgenerate

  assign add_sum  = mode_q ? ap_sum  : ex_sum;
  assign add_cout = mode_q ? ap_cout : ex_cout;
  assign add_res  = add_cout ? '1 : add_sum;

  assign n_clamp = (num_terms_i > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : num_terms_i;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    sat_d   = sat_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          n_d     = n_clamp;
          mode_d  = approx_en_i;
          state_d = (n_clamp == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid_i) begin
          acc_d = add_res;
          sat_d = sat_q | add_cout;
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      sat_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sat_q   <= sat_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready_o  = (state_q == S_ACCUM);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_sum_o   = acc_q;
  assign out_sat_o   = sat_q;

endmodule

// File: doc/approx_accum.md
# approx_accum

Parametrised multi-term accumulator for DNN dot-product partial sums. Each term is added with a configurable lower-part-OR approximate adder: the low APPROX_BITS bits use OR instead of full-adder cells, and the upper part is an exact ripple add. A start/count control FSM runs the block, with valid/ready handshakes on input terms and on the result. It sits after the multiplier array, replacing chains of single-bit full adders in the MAC datapath.

## Interface
- WIDTH, 8, input term width (unsigned)
- ACC_WIDTH, 16, accumulator/result width; must be ≥ WIDTH
- APPROX_BITS, 4, number of approximated LSBs; 0 = always exact; must be < WIDTH
- MAX_TERMS, 16, maximum terms per accumulation; CW = clog2(MAX_TERMS+1)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin new accumulation; honoured only in IDLE
- num_terms  input  CW  number of terms; sampled on accepted start
- approx_en  input  1  1 = approximate mode, 0 = exact; sampled on accepted start
- in_valid  input  1  term valid
- in_ready  output  1  block accepts term
- in_data  input  WIDTH  term, zero-extended to ACC_WIDTH
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_WIDTH  accumulated result
- out_sat  output  1  saturation occurred during this accumulation
- busy  output  1  high whenever state is not IDLE

## Operation
- States are IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears acc, cnt and sat, and latches n=min(num_terms,MAX_TERMS) and the mode.
  - If n==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each in_valid&&in_ready updates acc<=add(acc,op) and cnt<=cnt+1.
  - When the accepted term is term n (cnt==n-1), go to DONE.
- DONE:
  - out_valid=1; out_sum=acc and out_sat=sat are held stable.
  - out_ready=1 returns to IDLE. acc is not cleared until the next start.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored.
- add(a,b) with K=APPROX_BITS, when mode is approximate and K>0:
  - lo = a[K-1:0] | b[K-1:0]
  - cin = a[K-1] & b[K-1]
  - {cout,hi} = a[ACC_WIDTH-1:K] + b[ACC_WIDTH-1:K] + cin
- Exact mode: {cout,sum} = a + b over the full ACC_WIDTH.
- Saturation: if cout=1, the result is all-ones and sat<=1. sat stays set until the next start. Once acc is all-ones, further terms keep it saturated.
- out_sum always drives acc; it is meaningful only while out_valid=1.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, busy=0, out_sum=0, out_sat=0; cnt and n are cleared.
- Reset mid-operation abandons the accumulation with no result. The first start after release is honoured on the first rising edge with rst_n=1.
- start is accepted at edge T. busy=1 and in_ready=1 from T+1 (or out_valid=1 from T+1 if n==0).
- One term is accepted per cycle while in_valid=1; the add is single-cycle with no pipeline bubbles.
- Final term accepted at edge T: out_valid=1 and in_ready=0 from T+1. Latency from last term to result is 1 cycle.
- The result handshake completes at the edge with out_valid&&out_ready. Next cycle: IDLE, out_valid=0.
- The earliest next start is the cycle after returning to IDLE. start is not accepted in the same cycle as the result handshake.
- Throughput is n+2 cycles per accumulation with in_valid held high and out_ready=1.

## Test plan
- Exact mode: approx_en=0, n=3, terms 10,20,30 -> out_valid one cycle after the 3rd term, out_sum=60, out_sat=0.
- Approximate mode (K=4): approx_en=1, n=2, terms 0x0F,0x01 -> out_sum=0x000F. Then n=2, terms 0x08,0x08 -> out_sum=0x0018. Same stimulus in exact mode -> 0x0010 in both cases.
- Saturation: ACC_WIDTH=10, exact mode, n=5, all terms 255 -> out_sum=0x3FF, out_sat=1. Next run with n=1, term 1 -> out_sum=1, out_sat=0.
- Backpressure and gaps: in_valid toggles 1,0,1,0,1 with n=3; out_ready is held low for 5 cycles. Required: only valid cycles are counted; out_sum is stable and out_valid stays high while out_ready is low; start pulses in DONE are ignored; in_ready=0 in DONE.
- Zero/clamp: num_terms=0 -> out_valid the cycle after start, out_sum=0. num_terms=MAX_TERMS+1 (17) with all terms 1 -> exactly 16 terms are accepted, out_sum=16.
- Reset mid-run: rst_n pulsed low after 2 of 4 terms -> in_ready, out_valid, busy and out_sum are 0 immediately. A fresh start with n=1, term 7 -> out_sum=7.
